// File: rtl/mod_add_pipe_if.sv
// Stream interface of the pipelined modular adder: operand/modulus input
// stream and result output stream, each with its own valid/ready pair.
interface mod_add_pipe_if #(
    parameter int unsigned W = 28
);
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] q;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out;
    logic         out_valid;
    logic         out_ready;

    // Producer/consumer side (drives operands and consumes results)
    modport master (
        output x,
        output y,
        output q,
        output in_valid,
        input  in_ready,
        input  out,
        input  out_valid,
        output out_ready
    );

    // Adder side
    modport slave (
        input  x,
        input  y,
        input  q,
        input  in_valid,
        output in_ready,
        output out,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/mod_add_pipe.sv
// Two-stage pipelined modular adder: out = (x + y) mod q, with x, y < q.
// Stage 1 forms the raw sum and the sum minus q; stage 2 picks whichever
// is the reduced residue. A single enable stalls both stages together.
module mod_add_pipe #(
    parameter int unsigned W = 28
) (
    input logic           clk,
    input logic           rst,
    mod_add_pipe_if.slave bus
);

    logic         en;

    logic         s1_v_q;
    logic         s1_v_d;
    logic [W:0]   s1_z1_q;
    logic [W:0]   s1_z1_d;
    logic [W+1:0] s1_z2_q;
    logic [W+1:0] s1_z2_d;

    logic [W-1:0] out_q;
    logic [W-1:0] out_d;
    logic         out_valid_q;
    logic         out_valid_d;

    logic [W:0]   sum;
    logic [W+1:0] diff;
    logic         unused_bits;

    // Pipe advances whenever the output register is empty or being popped
    always_comb begin
        en = !out_valid_q || bus.out_ready;
    end

    assign bus.in_ready  = en;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;

    // Sum and trial subtraction of this cycle's operands
    always_comb begin
        sum  = {1'b0, bus.x} + {1'b0, bus.y};
        diff = {1'b0, sum} - {2'b00, bus.q};
    end

    // Stage 1 next state: load on advance, otherwise hold
    always_comb begin
        s1_v_d  = s1_v_q;
        s1_z1_d = s1_z1_q;
        s1_z2_d = s1_z2_q;
        if (en) begin
            s1_v_d  = bus.in_valid;
            s1_z1_d = sum;
            s1_z2_d = diff;
        end
    end

    // Stage 2 next state: non-negative difference means the sum reached q
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (en) begin
            out_valid_d = s1_v_q;
            out_d       = s1_z2_q[W+1] ? s1_z1_q[W-1:0] : s1_z2_q[W-1:0];
        end
    end

    // Top sum bit and bit W of the difference never reach the result: when
    // the difference is negative the sum is below q and fits in W bits.
    assign unused_bits = s1_z1_q[W] ^ s1_z2_q[W];

    // Stage 1 registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q  <= 1'b0;
            s1_z1_q <= '0;
            s1_z2_q <= '0;
        end else begin
            s1_v_q  <= s1_v_d;
            s1_z1_q <= s1_z1_d;
            s1_z2_q <= s1_z2_d;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

endmodule

// File: tb/tb_mod_add_pipe.sv
// Directed and randomised-backpressure bench for mod_add_pipe. A small cycle
// model of the two-stage pipe carries the hand-computed expected results.
module tb_mod_add_pipe;

    localparam int unsigned W = 28;
    localparam logic [W-1:0] QBIG = 28'd268369921;

    logic clk = 1'b0;
    logic rst;

    mod_add_pipe_if #(.W(W)) bus ();

    mod_add_pipe #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_pops   = 0;

    // Pipe model state
    bit           m_s1v = 1'b0;
    logic [W-1:0] m_s1val = '0;
    bit           m_ov = 1'b0;
    logic [W-1:0] m_out = '0;
    logic [W-1:0] cur_exp = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock cycle: compare DUT against the model before the edge,
    // then advance the model on the edge. acc reports an input transfer.
    task automatic tick(output bit acc);
        bit en;
        #1;
        en  = !m_ov || bus.out_ready;
        acc = bus.in_valid && en && !rst;
        check("out_valid", bus.out_valid, m_ov);
        check("in_ready", bus.in_ready, en);
        if (m_ov) check("out", bus.out, m_out);
        if (m_ov && bus.out_ready && !rst) n_pops++;
        @(posedge clk);
        if (rst) begin
            m_ov  = 1'b0;
            m_s1v = 1'b0;
        end else if (en) begin
            m_ov    = m_s1v;
            m_out   = m_s1val;
            m_s1v   = bus.in_valid;
            m_s1val = cur_exp;
        end
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] m, input logic [W-1:0] e);
        bit acc;
        bus.x = a;
        bus.y = b;
        bus.q = m;
        bus.in_valid = 1'b1;
        cur_exp = e;
        for (int i = 0; i < 32; i++) begin
            tick(acc);
            if (acc) return;
        end
        check("push_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int unsigned p0;
        logic [W-1:0] rx, ry, rq;
        logic [63:0] rs;

        rst = 1'b1;
        bus.x = '0;
        bus.y = '0;
        bus.q = 28'd2;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out", bus.out, 0);
        tick(acc);
        tick(acc);
        rst = 1'b0;
        idle(1);

        // Basic sum and latency
        p0 = n_pops;
        push(28'd5, 28'd7, QBIG, 28'd12);
        check("lat_edge1_ov", bus.out_valid, 0);
        idle(1);
        check("lat_edge2_ov", bus.out_valid, 1);
        check("lat_edge2_out", bus.out, 12);
        idle(2);
        check("basic_pops", n_pops - p0, 1);

        // Wrap cases
        p0 = n_pops;
        push(28'd268369920, 28'd1, QBIG, 28'd0);
        push(28'd268369920, 28'd268369920, QBIG, 28'd268369919);
        idle(3);
        check("wrap_pops", n_pops - p0, 2);

        // Per-transaction modulus, back to back
        p0 = n_pops;
        push(28'd10, 28'd9, 28'd17, 28'd2);
        push(28'd10, 28'd9, 28'd23, 28'd19);
        push(28'd0, 28'd0, 28'd2, 28'd0);
        idle(3);
        check("permod_pops", n_pops - p0, 3);

        // Random operands with random backpressure
        p0 = n_pops;
        for (int k = 0; k < 8; k++) begin
            rq = W'($urandom_range(2, 32'h0FFF_FFFF));
            rx = W'($urandom % rq);
            ry = W'($urandom % rq);
            rs = (64'(rx) + 64'(ry)) % 64'(rq);
            bus.x = rx;
            bus.y = ry;
            bus.q = rq;
            bus.in_valid = 1'b1;
            cur_exp = rs[W-1:0];
            acc = 1'b0;
            for (int i = 0; i < 64 && !acc; i++) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                tick(acc);
            end
            if (!acc) check("rand_accept", 0, 1);
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 16 && (m_ov || m_s1v); i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            tick(acc);
        end
        bus.out_ready = 1'b1;
        idle(3);
        check("rand_pops", n_pops - p0, 8);

        // Long stall with a held producer transaction
        p0 = n_pops;
        push(28'd100, 28'd200, 28'd1000, 28'd300);
        push(28'd999, 28'd999, 28'd1000, 28'd998);
        bus.out_ready = 1'b0;
        bus.x = 28'd1;
        bus.y = 28'd2;
        bus.q = 28'd5;
        cur_exp = 28'd3;
        for (int i = 0; i < 10; i++) begin
            tick(acc);
            check("stall_no_accept", acc, 0);
        end
        check("stall_out_held", bus.out, 300);
        bus.out_ready = 1'b1;
        tick(acc);
        check("release_accept", acc, 1);
        idle(4);
        check("stall_pops", n_pops - p0, 3);

        // Asynchronous reset with two transactions in flight
        p0 = n_pops;
        bus.out_ready = 1'b0;
        push(28'd1, 28'd1, 28'd17, 28'd2);
        push(28'd2, 28'd2, 28'd17, 28'd4);
        bus.in_valid = 1'b0;
        check("pre_rst_ov", bus.out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_ov", bus.out_valid, 0);
        check("async_rst_in_ready", bus.in_ready, 1);
        m_ov  = 1'b0;
        m_s1v = 1'b0;
        bus.out_ready = 1'b1;
        tick(acc);
        rst = 1'b0;
        idle(3);
        check("rst_no_stale", n_pops - p0, 0);
        push(28'd3, 28'd4, 28'd17, 28'd7);
        idle(1);
        check("post_rst_ov", bus.out_valid, 1);
        check("post_rst_out", bus.out, 7);
        idle(2);
        check("post_rst_pops", n_pops - p0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
